mmcm_reconfig_ctrl: RTL and testbench

Sequences run-time reconfiguration of the clock generator's MMCM through its dynamic reconfiguration port (DRP). On request it holds the MMCM in reset and applies one of several preset configurations as a series of read-modify-write register updates. It then releases reset and waits for lock. It sits beside the clock generator, runs on the same input clock domain as the DRP, and exposes a simple request/busy/done interface to system control logic.

---
 rtl/mmcm_reconfig_pkg.sv | 56 +++++
 rtl/mmcm_reconfig_if.sv | 29 ++
 rtl/mmcm_reconfig_rom.sv | 14 +
 rtl/mmcm_reconfig_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mmcm_reconfig_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmcm_reconfig_pkg.sv
// Shared types, sizes and preset DRP tables for the MMCM reconfiguration controller.
// Holds no logic beyond the read-modify-write merge helper.
package mmcm_reconfig_pkg;

    localparam int NUM_CFG      = 2;
    localparam int NUM_REGS     = 8;
    localparam int DRDY_TIMEOUT = 63;
    localparam int LOCK_TIMEOUT = 4095;
    localparam int BLANK_CYCLES = 4;

    localparam int SEL_W   = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int WD_W    = $clog2(LOCK_TIMEOUT + 1);

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RST_SETUP = 3'd1;
    localparam state_t ST_RD        = 3'd2;
    localparam state_t ST_RD_WAIT   = 3'd3;
    localparam state_t ST_WR        = 3'd4;
    localparam state_t ST_WR_WAIT   = 3'd5;
    localparam state_t ST_RELEASE   = 3'd6;
    localparam state_t ST_LOCK_WAIT = 3'd7;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    // mask bits set keep the MMCM's current register bit; cleared bits take data.
    localparam drp_entry_t CFG_TABLE [NUM_CFG][NUM_REGS] = '{
        '{ '{7'h08, 16'h1000, 16'h1145},
           '{7'h09, 16'hFC00, 16'h0000},
           '{7'h14, 16'h1000, 16'h0208},
           '{7'h15, 16'hFC00, 16'h0080},
           '{7'h16, 16'hC000, 16'h1041},
           '{7'h18, 16'hFC00, 16'h00FA},
           '{7'h19, 16'h8000, 16'h7C01},
           '{7'h1A, 16'h8000, 16'h7FE9} },
        '{ '{7'h08, 16'hF000, 16'h0123},
           '{7'h09, 16'hFC00, 16'h0000},
           '{7'h14, 16'h1000, 16'h0186},
           '{7'h15, 16'hFC00, 16'h0040},
           '{7'h16, 16'hC000, 16'h1041},
           '{7'h18, 16'hFC00, 16'h00C8},
           '{7'h19, 16'h8000, 16'h7C01},
           '{7'h1A, 16'h8000, 16'h7FE9} }
    };

    function automatic logic [15:0] drp_merge(input logic [15:0] cur, input drp_entry_t e);
        return (cur & e.mask) | (e.data & ~e.mask);
    endfunction

endpackage

// File: rtl/mmcm_reconfig_if.sv
// Control and DRP signal bundle between the reconfiguration controller and its surroundings.
// master = controller side, slave = system control / MMCM side.
interface mmcm_reconfig_if;
    import mmcm_reconfig_pkg::*;

    logic             req;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic             error;
    logic             mmcm_rst;
    logic             locked;
    logic [6:0]       daddr;
    logic [15:0]      di;
    logic             den;
    logic             dwe;
    logic [15:0]      do_in;
    logic             drdy;

    modport master (
        input  req, sel, locked, do_in, drdy,
        output busy, done, error, mmcm_rst, daddr, di, den, dwe
    );

    modport slave (
        output req, sel, locked, do_in, drdy,
        input  busy, done, error, mmcm_rst, daddr, di, den, dwe
    );
endinterface

// File: rtl/mmcm_reconfig_rom.sv
// Purpose: preset DRP entry lookup by (configuration, register index).
// Latency: combinational.
// Backpressure: none.
module mmcm_reconfig_rom
    import mmcm_reconfig_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [IDX_W-1:0] idx,
    output drp_entry_t       entry
);
    always_comb begin
        entry = CFG_TABLE[sel][idx];
    end
endmodule

// File: rtl/mmcm_reconfig_ctrl.sv
// Purpose: MMCM DRP read-modify-write sequencer; MMCM_RECONFIG_TIMEOUT_EN adds drdy/lock watchdogs.
// Latency: req -> busy/mmcm_rst +1 cycle, first den +2; 2k+2 cycles per register for drdy latency k.
// Backpressure: stalls on drdy and locked (bounded only with the watchdog); req ignored while busy.
module mmcm_reconfig_ctrl
    import mmcm_reconfig_pkg::*;
(
    input  logic            clk_in,
    input  logic            reset,
    mmcm_reconfig_if.master bus
);
    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   rom_idx;
    logic               busy_q;
    logic               done_q;
    logic               mmcm_rst_q;
    logic               den_q;
    logic               dwe_q;
    logic [6:0]         daddr_q;
    logic [15:0]        di_q;
    logic [BLANK_W-1:0] blank_q;
    logic               lock_meta_q;
    logic               lock_sync_q;
    logic               last_reg;
    drp_entry_t         entry;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
    logic [WD_W-1:0]    wd_q;
    logic               err_q;
`endif

    // Outputs are registered on the transition, so the lookup must already point
    // at the next register while the current write is completing.
    assign rom_idx  = (state_q == ST_WR_WAIT) ? idx_q + IDX_W'(1) : idx_q;
    assign last_reg = (idx_q == IDX_W'(NUM_REGS - 1));

    mmcm_reconfig_rom u_rom (
        .sel   (sel_q),
        .idx   (rom_idx),
        .entry (entry)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= bus.locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mmcm_rst_q <= 1'b0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            blank_q    <= '0;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        sel_q      <= bus.sel;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        mmcm_rst_q <= 1'b1;
                        state_q    <= ST_RST_SETUP;
                    end
                end
                ST_RST_SETUP: begin
                    den_q   <= 1'b1;
                    daddr_q <= entry.addr;
                    state_q <= ST_RD;
                end
                ST_RD: begin
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    wd_q    <= WD_W'(1);
`endif
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // Merge straight from do_in; the read value is needed for this one write only.
                    if (bus.drdy) begin
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        di_q    <= drp_merge(bus.do_in, entry);
                        state_q <= ST_WR;
                    end
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    else if (wd_q >= WD_W'(DRDY_TIMEOUT)) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                ST_WR: begin
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    wd_q    <= WD_W'(1);
`endif
                    state_q <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (bus.drdy) begin
                        if (last_reg) begin
                            mmcm_rst_q <= 1'b0;
                            state_q    <= ST_RELEASE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            den_q   <= 1'b1;
                            daddr_q <= entry.addr;
                            state_q <= ST_RD;
                        end
                    end
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    else if (wd_q >= WD_W'(DRDY_TIMEOUT)) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    blank_q <= BLANK_W'(BLANK_CYCLES);
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    wd_q    <= WD_W'(1);
`endif
                    state_q <= ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    // A stale lock from before reset release must not be trusted until blanking ends.
                    if (blank_q != '0) begin
                        blank_q <= blank_q - 1'b1;
                    end
                    if (blank_q == '0 && lock_sync_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`ifdef MMCM_RECONFIG_TIMEOUT_EN
                    else if (wd_q >= WD_W'(LOCK_TIMEOUT)) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mmcm_rst = mmcm_rst_q;
    assign bus.den      = den_q;
    assign bus.dwe      = dwe_q;
    assign bus.daddr    = daddr_q;
    assign bus.di       = di_q;
`ifdef MMCM_RECONFIG_TIMEOUT_EN
    assign bus.error    = err_q;
`else
    assign bus.error    = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Directed bench for mmcm_reconfig_ctrl: DRP responder with fixed drdy latency, table-driven access checks.
module tb_mmcm_reconfig_ctrl;

    logic clk_in;
    logic reset;

    mmcm_reconfig_if bus ();

    mmcm_reconfig_ctrl dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int          sel;
        int          idx;
        logic [15:0] rd;
        logic [6:0]  addr;
        logic [15:0] di;
    } vec_t;

    vec_t vecs [16];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          drp_lat = 3;
    int          drp_cnt = 0;
    bit          drdy_en = 1'b1;
    int          lock_delay = -1;
    int          poke_cyc = -1;
    int          req_cyc = 0;
    int          n_acc = 0;
    logic [6:0]  log_addr [32];
    logic [15:0] log_di   [32];
    logic        log_dwe  [32];
    int          log_cyc  [32];
    int          last_drdy_cyc = -1;
    int          rst_fall_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          err_cnt = 0;
    int          err_total = 0;
    int          err_cyc = -1;
    logic        err_rst = 1'b0;
    logic        err_busy = 1'b0;
    int          busy_bad = 0;
    int          double_den = 0;
    logic        prev_den = 1'b0;
    logic        prev_rst = 1'b0;
    logic        prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs just after the edge, then drive the DRP/lock models.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        bus.drdy = 1'b0;
        if (drp_cnt > 0) begin
            drp_cnt--;
            if (drp_cnt == 0 && drdy_en) begin
                bus.drdy = 1'b1;
                last_drdy_cyc = cyc;
            end
        end
        if (bus.den) begin
            if (prev_den) double_den++;
            if (n_acc < 32) begin
                log_addr[n_acc] = bus.daddr;
                log_di[n_acc]   = bus.di;
                log_dwe[n_acc]  = bus.dwe;
                log_cyc[n_acc]  = cyc;
            end
            n_acc++;
            drp_cnt = drp_lat;
        end
        prev_den = bus.den;
        if (prev_rst && !bus.mmcm_rst) rst_fall_cyc = cyc;
        prev_rst = bus.mmcm_rst;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.busy || !prev_busy) busy_bad++;
        end
        if (bus.error) begin
            err_cnt++;
            err_total++;
            err_cyc  = cyc;
            err_rst  = bus.mmcm_rst;
            err_busy = bus.busy;
        end
        prev_busy = bus.busy;
        if (lock_delay >= 0 && rst_fall_cyc >= 0 && cyc >= rst_fall_cyc + lock_delay) bus.locked = 1'b1;
        bus.req = (cyc == poke_cyc);
    endtask

    task automatic start(input int s, input logic [15:0] rd, input int k);
        n_acc = 0;
        done_cnt = 0;
        done_cyc = -1;
        err_cnt = 0;
        err_cyc = -1;
        rst_fall_cyc = -1;
        last_drdy_cyc = -1;
        busy_bad = 0;
        bus.sel = 1'(s);
        bus.do_in = rd;
        drp_lat = k;
        bus.req = 1'b1;
        req_cyc = cyc;
        step();
    endtask

    task automatic wait_end(input string tag, input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < max) begin
            step();
            n++;
        end
        check({tag, " finished"}, 32'((done_cnt + err_cnt) > 0), 1);
    endtask

    task automatic check_log(input int s);
        int a;
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].sel == s) begin
                a = 2 * vecs[v].idx;
                check($sformatf("rd_addr s%0d i%0d", s, vecs[v].idx), 32'(log_addr[a]), 32'(vecs[v].addr));
                check($sformatf("wr_addr s%0d i%0d", s, vecs[v].idx), 32'(log_addr[a+1]), 32'(vecs[v].addr));
                check($sformatf("wr_di s%0d i%0d", s, vecs[v].idx), 32'(log_di[a+1]), 32'(vecs[v].di));
                check($sformatf("dwe seq s%0d i%0d", s, vecs[v].idx), 32'({log_dwe[a], log_dwe[a+1]}), 32'(2'b01));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n;
        // sel 0 read back as A5A5, sel 1 read back as FFFF: di = (rd & mask) | (data & ~mask)
        vecs[0]  = '{0, 0, 16'hA5A5, 7'h08, 16'h0145};
        vecs[1]  = '{0, 1, 16'hA5A5, 7'h09, 16'hA400};
        vecs[2]  = '{0, 2, 16'hA5A5, 7'h14, 16'h0208};
        vecs[3]  = '{0, 3, 16'hA5A5, 7'h15, 16'hA480};
        vecs[4]  = '{0, 4, 16'hA5A5, 7'h16, 16'h9041};
        vecs[5]  = '{0, 5, 16'hA5A5, 7'h18, 16'hA4FA};
        vecs[6]  = '{0, 6, 16'hA5A5, 7'h19, 16'hFC01};
        vecs[7]  = '{0, 7, 16'hA5A5, 7'h1A, 16'hFFE9};
        vecs[8]  = '{1, 0, 16'hFFFF, 7'h08, 16'hF123};
        vecs[9]  = '{1, 1, 16'hFFFF, 7'h09, 16'hFC00};
        vecs[10] = '{1, 2, 16'hFFFF, 7'h14, 16'h1186};
        vecs[11] = '{1, 3, 16'hFFFF, 7'h15, 16'hFC40};
        vecs[12] = '{1, 4, 16'hFFFF, 7'h16, 16'hD041};
        vecs[13] = '{1, 5, 16'hFFFF, 7'h18, 16'hFCC8};
        vecs[14] = '{1, 6, 16'hFFFF, 7'h19, 16'hFC01};
        vecs[15] = '{1, 7, 16'hFFFF, 7'h1A, 16'hFFE9};

        reset = 1'b1;
        bus.req = 1'b0;
        bus.sel = '0;
        bus.locked = 1'b0;
        bus.do_in = '0;
        bus.drdy = 1'b0;
        repeat (3) step();
        check("reset ctrl outputs", 32'({bus.busy, bus.done, bus.error, bus.mmcm_rst, bus.den, bus.dwe}), 0);
        check("reset daddr", 32'(bus.daddr), 0);
        check("reset di", 32'(bus.di), 0);
        reset = 1'b0;
        step();

        // Basic write, sel 1, drdy 3 cycles after den, lock raised 10 cycles after release
        lock_delay = 10;
        start(1, vecs[8].rd, 3);
        check("busy at N+1", 32'(bus.busy), 1);
        check("mmcm_rst at N+1", 32'(bus.mmcm_rst), 1);
        check("den at N+1", 32'(bus.den), 0);
        wait_end("basic", 400);
        repeat (5) step();
        check("basic access count", n_acc, 16);
        check_log(1);
        check("first den latency", log_cyc[0] - req_cyc, 2);
        check("register period k=3", log_cyc[2] - log_cyc[0], 8);
        check("rst release after last drdy", rst_fall_cyc - last_drdy_cyc, 1);
        check("done after late lock", done_cyc - rst_fall_cyc, 13);
        check("basic done count", done_cnt, 1);
        check("busy falls with done", busy_bad, 0);
        lock_delay = -1;

        // Early lock held through blanking; a second req mid-run must be ignored
        start(0, vecs[0].rd, 2);
        bus.sel = 1'b1;
        poke_cyc = cyc + 15;
        wait_end("ignored req", 400);
        repeat (10) step();
        poke_cyc = -1;
        check("ignored req access count", n_acc, 16);
        check_log(0);
        check("register period k=2", log_cyc[2] - log_cyc[0], 6);
        check("early lock blanked", 32'((done_cyc - rst_fall_cyc) >= 6 && (done_cyc - rst_fall_cyc) <= 7), 1);
        check("ignored req done count", done_cnt, 1);

        // Reset during the third WR_WAIT, then restart
        start(1, vecs[8].rd, 3);
        n = 0;
        while (n_acc < 6 && n < 200) begin
            step();
            n++;
        end
        check("reached third write", n_acc, 6);
        step();
        reset = 1'b1;
        step();
        check("mid reset ctrl outputs", 32'({bus.busy, bus.done, bus.error, bus.mmcm_rst, bus.den, bus.dwe}), 0);
        check("mid reset daddr", 32'(bus.daddr), 0);
        check("mid reset di", 32'(bus.di), 0);
        reset = 1'b0;
        start(1, vecs[8].rd, 3);
        wait_end("restart", 400);
        repeat (3) step();
        check("restart access count", n_acc, 16);
        check_log(1);
        check("restart done count", done_cnt, 1);

`ifdef MMCM_RECONFIG_TIMEOUT_EN
        drdy_en = 1'b0;
        start(0, vecs[0].rd, 3);
        wait_end("drdy timeout", 300);
        check("drdy timeout cycle", err_cyc - log_cyc[0], 64);
        check("drdy timeout mmcm_rst", 32'(err_rst), 0);
        check("drdy timeout busy", 32'(err_busy), 0);
        check("drdy timeout accesses", n_acc, 1);
        drdy_en = 1'b1;
        repeat (3) step();

        bus.locked = 1'b0;
        start(1, vecs[8].rd, 1);
        wait_end("lock timeout", 6000);
        check("lock timeout error", err_cnt, 1);
        check("lock timeout no done", done_cnt, 0);
        check("lock timeout cycle", 32'((err_cyc - rst_fall_cyc) >= 4095 && (err_cyc - rst_fall_cyc) <= 4096), 1);
        check("lock timeout busy", 32'(err_busy), 0);
`else
        bus.locked = 1'b0;
        start(1, vecs[8].rd, 1);
        n = 0;
        while (rst_fall_cyc < 0 && n < 200) begin
            step();
            n++;
        end
        repeat (300) step();
        check("lock wait busy held", 32'(bus.busy), 1);
        check("lock wait no done", done_cnt, 0);
        check("error never pulses", err_total, 0);
        bus.locked = 1'b1;
        wait_end("late lock", 50);
        check("late lock done count", done_cnt, 1);
`endif

        check("no back-to-back den", double_den, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
